// File: rtl/sram_arb_pkg.sv
// Shared types and default geometry for the two-requester SRAM port arbiter.
package sram_arb_pkg;

  localparam int DEPTH_DEF  = 512;
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 64;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic req_id_t;

  // Only valid for one-hot or zero input; zero maps to requester 0.
  function automatic req_id_t onehot_to_id(input logic [1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, zero latency, no backpressure.
// After a grant the pointer favours the requester that lost; idle cycles keep it.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTB,
  input  logic [1:0] eligible,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_t ptr;

  always_comb begin
    grant = 2'b00;
    unique case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between two requesters after a zero-fill sweep; read data one cycle after grant.
// Reads are withheld while a response is blocked (one-entry skid holds it); writes always proceed.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                CLK,
  input  logic                RSTB,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_wen,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done,
  output logic                sram_ceb,
  output logic                sram_web,
  output logic [ADDR_W-1:0]   sram_a,
  output logic [DATA_W-1:0]   sram_d,
  input  logic [DATA_W-1:0]   sram_q
);

  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              sweep_last;
  logic              sweep_wr;

  logic              rd_inflight;
  req_id_t           inflight_id;
  logic              hold_vld;
  req_id_t           hold_id;
  logic [DATA_W-1:0] hold_dat;

  logic              rd_gate;
  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic              granted;
  req_id_t           win_id;
  logic              grant_rd;

  assign sweep_last = (sweep_cnt == ADDR_W'(DEPTH - 1));
  assign init_done  = (state == RUN);
  // Gated by RSTB so the macro is never written while reset is held.
  assign sweep_wr   = RSTB && (state == INIT) && INIT_ZERO;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else if (state == INIT) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (!INIT_ZERO || sweep_last) begin
        state <= RUN;
      end
    end
  end

  // A read may only issue if its response can land somewhere next cycle.
  assign rd_gate = !hold_vld && !(rd_inflight && !rsp_ready[inflight_id]);

  always_comb begin
    eligible = 2'b00;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = init_done && req_valid[i] && (req_wen[i] || rd_gate);
    end
  end

  rr_arb2 u_arb (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .eligible (eligible),
    .advance  (granted),
    .grant    (grant)
  );

  assign granted   = |grant;
  assign win_id    = onehot_to_id(grant);
  assign grant_rd  = granted && !req_wen[win_id];
  assign req_ready = grant;

  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (sweep_wr) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = sweep_cnt;
    end else if (granted) begin
      sram_ceb = 1'b0;
      sram_web = req_wen[win_id] ? 1'b0 : 1'b1;
      sram_a   = win_id ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
      sram_d   = win_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      rd_inflight <= 1'b0;
      inflight_id <= 1'b0;
      hold_vld    <= 1'b0;
      hold_id     <= 1'b0;
      hold_dat    <= '0;
    end else begin
      rd_inflight <= grant_rd;
      if (grant_rd) begin
        inflight_id <= win_id;
      end
      // sram_q is only meaningful this one cycle, so a stalled response is captured now.
      if (rd_inflight && !rsp_ready[inflight_id]) begin
        hold_vld <= 1'b1;
        hold_id  <= inflight_id;
        hold_dat <= sram_q;
      end else if (hold_vld && rsp_ready[hold_id]) begin
        hold_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (hold_vld) begin
      rsp_valid[hold_id] = 1'b1;
    end else if (rd_inflight) begin
      rsp_valid[inflight_id] = 1'b1;
    end
  end

  assign rsp_rdata = hold_vld ? hold_dat : (rd_inflight ? sram_q : '0);

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Controller that shares one single-port 512x64 SRAM macro (active-low chip/write enable, one-cycle read latency, output undefined on non-read cycles) between two requesters. It zero-fills the array after reset and arbitrates read/write requests round-robin, one access per cycle. It returns read data through a per-requester valid/ready response channel with a one-entry skid register, so the macro output is only ever sampled in the cycle after a read. It sits between the cache/buffer logic and the macro pins.

## Interface
- DEPTH, 512, words in the macro
- ADDR_W, 9, address width (log2 DEPTH)
- DATA_W, 64, data width
- INIT_ZERO, 1, 1 = zero-fill sweep after reset; 0 = skip
- CLK  in  1  clock; single clock domain
- RSTB  in  1  reset, asynchronous, active-low
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted this cycle
- req_wen  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_W  address; requester i in slice i
- req_wdata  in  2*DATA_W  write data; requester i in slice i
- rsp_valid  out  2  read data valid for requester i
- rsp_ready  in  2  requester i takes read data
- rsp_rdata  out  DATA_W  read data (shared; owner given by rsp_valid)
- init_done  out  1  sweep complete, requests accepted
- sram_ceb  out  1  macro chip enable, active-low
- sram_web  out  1  macro write enable, active-low (0 = write)
- sram_a  out  ADDR_W  macro address
- sram_d  out  DATA_W  macro write data
- sram_q  in  DATA_W  macro read data

## Operation
- States: INIT, RUN.
- Reset (RSTB=0) enters INIT with sweep counter 0. If INIT_ZERO=0, go straight to RUN.
- INIT: each cycle write zero to address = counter (ceb=0, web=0), then increment. After writing DEPTH-1, go to RUN. req_ready=0 throughout.
- RUN, arbitration:
  - Candidates are requesters with req_valid=1. A read is eligible only if the read gate is open.
  - Read gate: hold_valid=0 and NOT (rd_inflight=1 and rsp_ready[inflight_id]=0).
  - With two eligible requesters, a round-robin pointer selects. The pointer moves to the other requester after every grant and is unchanged on idle cycles. Reset pointer favours requester 0.
  - The winner gets req_ready=1 and its address/data/wen drive the macro that cycle.
  - No grant: sram_ceb=1, sram_web=1.
- Writes produce no response.
- Read pipeline:
  - A granted read sets rd_inflight and inflight_id for the next cycle.
  - In that cycle rsp_valid[id]=1 and rsp_rdata=sram_q.
  - If rsp_ready[id]=0, sram_q is captured into the hold register (hold_valid=1).
  - While hold_valid=1: rsp_rdata=hold, stable until rsp_ready[id]=1 clears it.
- Ordering is macro order: a read granted the cycle after a write to the same address returns the new data.

## Timing
- Reset values: req_ready=0, rsp_valid=0, init_done=0, sram_ceb=1, sram_web=1, sram_a=0, sram_d=0, hold_valid=0, rd_inflight=0.
- req_ready and sram_* are combinational from req_valid/state. The macro samples at the end of the grant cycle.
- Read latency: grant at cycle t gives rsp_valid at t+1.
- Throughput: one access per cycle; back-to-back reads sustain 1/cycle while rsp_ready=1.
- init_done rises the first RUN cycle (cycle DEPTH after reset release when INIT_ZERO=1).
- Reset mid-INIT restarts the sweep at address 0.
- Reset mid-read drops rd_inflight and hold; no response is produced.
- rsp_valid never deasserts without handshake, and rsp_rdata is stable while rsp_valid=1 and rsp_ready=0.
- Writes remain grantable while a response is blocked; only reads are gated.

## Structure
- Package sram_arb_pkg holds: state enum (INIT, RUN); default ADDR_W/DATA_W/DEPTH constants; requester id type (1 bit).
- Sub-module rr_arb2: two-way round-robin arbiter with pointer register; inputs eligible[1:0] and advance, output one-hot grant.
- Top level holds the sweep counter, read pipeline/skid register and macro-side muxing.

## Test plan
- Reset release, INIT_ZERO=1 -> exactly 512 writes of 0 to addresses 0..511, init_done=1 at cycle 512; read addr 5 returns 0x0.
- Requester 0 writes 0xDEAD_BEEF_0123_4567 to 0x1A3; requester 1 reads 0x1A3 next cycle -> rsp_valid[1]=1 one cycle later with that data.
- Both requesters valid with reads every cycle, rsp_ready=2'b11 -> grants alternate 0,1,0,1; one response per cycle in order.
- Read by requester 0 with rsp_ready[0]=0 for 3 cycles -> rsp_rdata held constant; requester 1 writes still granted; requester 1 reads blocked until handshake.
- Read granted, rsp_ready=0 the next cycle, then macro idles (sram_q garbage) -> response still shows the captured data.
- RSTB pulsed low at sweep address 200 -> sweep restarts at 0, init_done rises 512 cycles after release, no stale rsp_valid.
